// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer_if
// Description : Request/result bundle between the EX stage and the
//               multiply/divide sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface mdu_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, data_a, data_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data_a, data_b, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer
// Description : Bit-serial MULT/MULTU/DIV/DIVU engine with the architectural
//               HI/LO registers, single-cycle MTHI/MTLO and flush abort.
// Revision    : 1.0  initial release
// ============================================================================
module mdu_sequencer (
    input  wire logic        clk,
    input  wire logic        reset,
    mdu_sequencer_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [4:0] C_LAST_STEP = 5'd31;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic        r_is_div;
    logic        r_neg_res;   // product / quotient must be negated
    logic        r_neg_rem;   // remainder takes the dividend sign
    logic        r_div_zero;
    logic [31:0] r_opb;       // multiplicand or divisor magnitude
    logic [31:0] r_work_hi;   // upper product half or partial remainder
    logic [31:0] r_work_lo;   // multiplier / dividend shifting out, result shifting in
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed_op;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Operand magnitudes and per-step datapath arithmetic
    always_comb begin
        w_signed_op = ~bus.op[0];
        w_abs_a     = (w_signed_op && bus.data_a[31]) ? (32'd0 - bus.data_a) : bus.data_a;
        w_abs_b     = (w_signed_op && bus.data_b[31]) ? (32'd0 - bus.data_b) : bus.data_b;

        // Shift-add: add multiplicand when the current multiplier bit is set
        w_mul_sum   = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opb} : 33'd0);

        // Restoring division: the remainder stays below the divisor, so the
        // shifted value fits in 33 bits and bit 32 of the trial is the borrow
        w_div_shift = {r_work_hi, r_work_lo[31]};
        w_div_trial = w_div_shift - {1'b0, r_opb};

        w_prod      = {r_work_hi, r_work_lo};
        w_prod_fix  = r_neg_res ? (64'd0 - w_prod) : w_prod;
        // Divide-by-zero: quotient is all ones; the remainder path already
        // reproduces the original dividend once the dividend sign is applied
        w_quo_fix   = r_div_zero ? 32'hFFFF_FFFF
                                 : (r_neg_res ? (32'd0 - r_work_lo) : r_work_lo);
        w_rem_fix   = r_neg_rem ? (32'd0 - r_work_hi) : r_work_hi;
    end

    // Sequencer state, iteration datapath and HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= 5'd0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_opb      <= 32'd0;
            r_work_hi  <= 32'd0;
            r_work_lo  <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                // Abort anything in flight and drop any request this cycle
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start && !bus.op[2]) begin
                            r_is_div   <= bus.op[1];
                            r_neg_res  <= w_signed_op & (bus.data_a[31] ^ bus.data_b[31]);
                            r_neg_rem  <= w_signed_op & bus.data_a[31];
                            r_div_zero <= (bus.data_b == 32'd0);
                            r_opb      <= w_abs_b;
                            r_work_hi  <= 32'd0;
                            r_work_lo  <= w_abs_a;
                            r_count    <= 5'd0;
                            r_busy     <= 1'b1;
                            r_state    <= RUN;
                        end else if (bus.start && !bus.op[1]) begin
                            if (bus.op[0]) begin
                                r_lo <= bus.data_a;
                            end else begin
                                r_hi <= bus.data_a;
                            end
                            r_done <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (r_is_div) begin
                            r_work_hi <= w_div_trial[32] ? w_div_shift[31:0] : w_div_trial[31:0];
                            r_work_lo <= {r_work_lo[30:0], ~w_div_trial[32]};
                        end else begin
                            r_work_hi <= w_mul_sum[32:1];
                            r_work_lo <= {w_mul_sum[0], r_work_lo[31:1]};
                        end
                        r_count <= r_count + 5'd1;
                        if (r_count == C_LAST_STEP) begin
                            r_state <= FIX;
                        end
                    end
                    FIX: begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[63:32];
                            r_lo <= w_prod_fix[31:0];
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sequencer
// Description : Directed self-checking bench for mdu_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op, scramble operands while it runs, optionally
    // re-pulse start at sample index poke, then check latency and results.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int poke);
        int n;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.data_a = a;
        bus.data_b = b;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            bus.data_a = $urandom;
            bus.data_b = $urandom;
            bus.start  = (n == poke);
            tick();
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " hi"}, 64'(bus.hi), 64'(eh));
        check({tag, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        int cnt;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.data_a = 32'd0;
        bus.data_b = 32'd0;
        bus.flush  = 1'b0;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
        tick();
        check("mult done_pulse_end", 64'(bus.done), 64'd0);

        // Back-to-back: each op starts in the cycle its predecessor shows done
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, -1);
        run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
        tick();

        // Start re-pulsed during RUN cycle 5 must be ignored
        run_op("ignore_start", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 6);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.busy === 1'b1 || bus.done === 1'b1) cnt++;
        end
        check("ignore_start no_second_op", 64'(cnt), 64'd0);

        // Flush at RUN cycle 10
        bus.start  = 1'b1;
        bus.op     = OP_MULT;
        bus.data_a = 32'h100;
        bus.data_b = 32'h100;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) cnt++;
        end
        check("flush no_done", 64'(cnt), 64'd0);
        check("flush hi", 64'(bus.hi), 64'd0);
        check("flush lo", 64'(bus.lo), 64'd6);

        // Flush in IDLE drops an MTLO request
        bus.start  = 1'b1;
        bus.op     = OP_MTLO;
        bus.data_a = 32'hAAAA_AAAA;
        bus.flush  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_mtlo lo", 64'(bus.lo), 64'd6);
        check("flush_mtlo done", 64'(bus.done), 64'd0);

        // MTHI / MTLO
        bus.start  = 1'b1;
        bus.op     = OP_MTHI;
        bus.data_a = 32'h1234_5678;
        tick();
        bus.start = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi done", 64'(bus.done), 64'd1);
        check("mthi busy", 64'(bus.busy), 64'd0);
        check("mthi lo_kept", 64'(bus.lo), 64'd6);
        bus.start  = 1'b1;
        bus.op     = OP_MTLO;
        bus.data_a = 32'hCAFE_F00D;
        tick();
        bus.start = 1'b0;
        check("mtlo lo", 64'(bus.lo), 64'hCAFE_F00D);
        check("mtlo done", 64'(bus.done), 64'd1);
        tick();
        check("mtlo done_end", 64'(bus.done), 64'd0);

        // Invalid op is ignored
        bus.start = 1'b1;
        bus.op    = 3'b110;
        tick();
        bus.start = 1'b0;
        tick();
        check("invalid busy", 64'(bus.busy), 64'd0);
        check("invalid done", 64'(bus.done), 64'd0);
        check("invalid hi", 64'(bus.hi), 64'h1234_5678);

        // Asynchronous reset in the middle of RUN
        bus.start  = 1'b1;
        bus.op     = OP_MULT;
        bus.data_a = 32'd5;
        bus.data_b = 32'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        check("async_reset busy", 64'(bus.busy), 64'd0);
        check("async_reset done", 64'(bus.done), 64'd0);
        check("async_reset hi", 64'(bus.hi), 64'd0);
        check("async_reset lo", 64'(bus.lo), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_op("mult_after_reset", OP_MULT, 32'd4, 32'd4, 32'd0, 32'd16, -1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
